two_comp_seq_ctrl: RTL and testbench

TWO_COMP_SEQ_CTRL -- requirements
Module: two_comp_seq_ctrl

---
 rtl/two_comp_pkg.sv | 12 +
 rtl/serial_comp_cell.sv | 25 ++
 rtl/two_comp_seq_ctrl.sv | 106 ++++++++++
 tb/tb_two_comp_seq_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/two_comp_pkg.sv
// Shared types and constants for the bit-serial two's complement negator.
package two_comp_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_comp_cell.sv
// Serial two's complement cell: copy bits up to and including the first 1, invert after.
module serial_comp_cell (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic bit_out
);

    logic seen_one;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_one <= 1'b0;
        end else if (clr) begin
            seen_one <= 1'b0;
        end else if (en && bit_in) begin
            seen_one <= 1'b1;
        end
    end

    assign bit_out = seen_one ? ~bit_in : bit_in;

endmodule

// File: rtl/two_comp_seq_ctrl.sv
// Sequential negator: accepts one operand, negates it LSB-first over WIDTH cycles, holds the result.
module two_comp_seq_ctrl
    import two_comp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and data is stable while valid is held.

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             ovf_q;
    logic             accept;
    logic             cell_en;
    logic             cell_out;

    assign accept  = (state == IDLE) && in_valid;
    assign cell_en = (state == SHIFT);

    serial_comp_cell u_cell (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (cell_en),
        .bit_in  (op_q[0]),
        .bit_out (cell_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)      state_nxt = SHIFT;
            SHIFT:   if (cnt_q == LAST) state_nxt = DONE;
            DONE:    if (out_ready)     state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        dbg_state = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= '0;
            res_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= in_data;
                        res_q <= '0;
                        cnt_q <= '0;
                        ovf_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    op_q  <= op_q >> 1;
                    res_q <= {cell_out, res_q[WIDTH-1:1]};
                    if (cnt_q != LAST) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        // On the final bit op_q[0] is the operand MSB and cell_out the result MSB.
                        ovf_q <= op_q[0] & cell_out;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = res_q;
    assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_two_comp_seq_ctrl.sv
// Directed bench for two_comp_seq_ctrl: negation, backpressure, reset abort, busy-ignore, full sweep.
module tb_two_comp_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf;
    logic       busy;
    logic [1:0] dbg_state;

    int         n_tests;
    int         n_fail;
    logic [7:0] exp_q[$];

    two_comp_seq_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // driver: present x, wait for in_ready, complete acceptance on the next edge
    task automatic accept(input logic [7:0] x, input bit hold_valid);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        if (!hold_valid) in_valid = 1'b0;
    endtask

    // returns the number of edges from the current point until out_valid is seen
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        if (lat >= 40) check("valid_timeout", 32'(lat), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [7:0] x,
                          input logic [7:0] exp_d, input logic exp_o);
        int lat;
        accept(x, 1'b0);
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'd8);
        @(negedge clk);
        check({tag, "_data"}, 32'(out_data), 32'(exp_d));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(exp_o));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        int         lat;
        logic [7:0] e;
        n_tests = 0;
        n_fail  = 0;

        do_reset();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        run_op("neg05", 8'h05, 8'hFB, 1'b0);
        run_op("zero", 8'h00, 8'h00, 1'b0);
        run_op("mostneg", 8'h80, 8'h80, 1'b1);
        run_op("neg01", 8'h01, 8'hFF, 1'b0);
        run_op("neg7f", 8'h7F, 8'h81, 1'b0);

        // backpressure: result must hold for 5 cycles with out_ready low
        accept(8'h01, 1'b0);
        check("bp_busy_shift", 32'(busy), 32'd1);
        check("bp_state_shift", 32'(dbg_state), 32'd1);
        wait_valid(lat);
        check("bp_lat", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_data", 32'(out_data), 32'hFF);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // reset in the third SHIFT cycle aborts the operation
        accept(8'h3C, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_pre_state", 32'(dbg_state), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check("abort_no_result", 32'(out_valid), 32'd0);
        end
        run_op("resend3c", 8'h3C, 8'hC4, 1'b0);

        // in_valid held high with a new operand while busy
        accept(8'h7F, 1'b1);
        in_data = 8'h11;
        wait_valid(lat);
        check("busy_lat", 32'(lat), 32'd8);
        @(negedge clk);
        check("busy_data", 32'(out_data), 32'h81);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("busy_idle_after_hs", 32'(dbg_state), 32'd0);
        check("busy_in_ready_after_hs", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("busy_second_accept", 32'(busy), 32'd1);
        wait_valid(lat);
        check("busy2_lat", 32'(lat), 32'd8);
        @(negedge clk);
        check("busy2_data", 32'(out_data), 32'hEF);
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // full sweep, back-to-back, consumer always ready
        for (int x = 0; x < 256; x++) begin
            e = 8'(256 - x);
            exp_q.push_back(e);
            accept(8'(x), 1'b0);
            wait_valid(lat);
            e = exp_q.pop_front();
            check("sweep_data", 32'(out_data), 32'(e));
            check("sweep_ovf", 32'(out_ovf), (x == 128) ? 32'd1 : 32'd0);
        end
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
